// File: rtl/spi_regbank.sv
// SPI mode-0 peripheral owning NUM_REGS x DATA_W config registers with read-back.
// Pins are synchronised into clk; writes commit on the detected ncs rise of a well-formed frame.
`timescale 1ns/1ps
module spi_regbank #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ncs,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  ncs_s, sclk_s, copi_s;
  logic                    ncs_d, sclk_d;
  logic                    ncs_rise, ncs_fall, sclk_rise, sclk_fall, copi_bit;
  logic [CNT_W-1:0]        cnt_q;
  logic                    rw_q, ovf_q;
  logic [ADDR_W-1:0]       addr_q, addr_nx;
  logic [ADDR_W:0]         addr_cat;
  logic [DATA_W-1:0]       sh_q, sh_in, sh_left, rd_word;
  logic [DATA_W:0]         sh_cat_in, sh_cat_z;
  logic                    addr_last, data_last, addr_ok, commit_wr, commit_err;
  logic [DATA_W-1:0]       regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_s  <= '1;
      sclk_s <= '0;
      copi_s <= '0;
      ncs_d  <= 1'b1;
      sclk_d <= 1'b0;
    end else begin
      ncs_s  <= {ncs_s[SYNC_STAGES-2:0], ncs};
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      copi_s <= {copi_s[SYNC_STAGES-2:0], copi};
      ncs_d  <= ncs_s[SYNC_STAGES-1];
      sclk_d <= sclk_s[SYNC_STAGES-1];
    end
  end

  assign ncs_rise  =  ncs_s[SYNC_STAGES-1] & ~ncs_d;
  assign ncs_fall  = ~ncs_s[SYNC_STAGES-1] &  ncs_d;
  assign sclk_rise =  sclk_s[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[SYNC_STAGES-1] &  sclk_d;
  assign copi_bit  =  copi_s[SYNC_STAGES-1];

  assign addr_last = (cnt_q == CNT_W'(ADDR_W - 1));
  assign data_last = (cnt_q == CNT_W'(DATA_W - 1));
  assign addr_cat  = {addr_q, copi_bit};
  assign addr_nx   = addr_cat[ADDR_W-1:0];
  assign sh_cat_in = {sh_q, copi_bit};
  assign sh_cat_z  = {sh_q, 1'b0};
  assign sh_in     = sh_cat_in[DATA_W-1:0];
  assign sh_left   = sh_cat_z[DATA_W-1:0];
  assign addr_ok   = int'(addr_q) < NUM_REGS;

  // Read word is selected with the address bit being sampled this cycle.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (int'(addr_nx) == k) rd_word = regs[k];
  end

  assign commit_wr  = ncs_rise && state_q == DONE && !ovf_q && rw_q && addr_ok;
  assign commit_err = ncs_rise && state_q != IDLE &&
                      !(state_q == DONE && !ovf_q && (!rw_q || addr_ok));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ncs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ncs_fall) state_d = CMD;
        CMD:     if (sclk_rise) state_d = ADDR;
        ADDR:    if (sclk_rise && addr_last) state_d = DATA;
        DATA:    if (sclk_rise && data_last) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      ovf_q     <= 1'b0;
      addr_q    <= '0;
      sh_q      <= '0;
      cipo_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_strobe <= commit_wr;
      frame_err <= commit_err;
      if (commit_wr) wr_addr <= addr_q;
      if (ncs_rise) begin
        cipo_oe <= 1'b0;
        sh_q    <= '0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (ncs_fall) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end
          CMD: if (sclk_rise) begin
            rw_q  <= copi_bit;
            cnt_q <= '0;
          end
          ADDR: if (sclk_rise) begin
            addr_q <= addr_nx;
            if (addr_last) begin
              cnt_q <= '0;
              if (!rw_q) begin
                sh_q    <= rd_word;
                cipo_oe <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DATA: begin
            if (sclk_rise) begin
              if (rw_q) sh_q <= sh_in;
              cnt_q <= data_last ? '0 : cnt_q + CNT_W'(1);
            // The fall right after the last address bit must keep the freshly loaded MSB.
            end else if (sclk_fall && !rw_q && cnt_q != '0) begin
              sh_q <= sh_left;
            end
          end
          DONE: if (sclk_rise) ovf_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (commit_wr) begin
      for (int k = 0; k < NUM_REGS; k++)
        if (int'(addr_q) == k) regs[k] <= sh_q;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_q[k*DATA_W +: DATA_W] = regs[k];
  end

  assign cipo = cipo_oe & sh_q[DATA_W-1];
endmodule

// File: doc/spi_regbank.md
# spi_regbank

Parametrised SPI (mode 0) peripheral that owns a bank of `NUM_REGS` configuration registers of `DATA_W` bits each. It succeeds the fixed 5×8-bit write-only peripheral. It adds:
- parametrised width, depth and address size;
- read-back on `cipo`;
- exact frame-length validation;
- per-register writes that leave all other registers untouched.

It sits between the chip-level SPI pins and the output-enable/PWM control logic, and is clocked entirely in the system `clk` domain.

## Interface
Parameters:
- `DATA_W`, 8, register and data-phase width in bits (≥1)
- `ADDR_W`, 7, address-phase width in bits (≥1)
- `NUM_REGS`, 5, number of implemented registers (1..2^ADDR_W)
- `SYNC_STAGES`, 2, synchroniser depth for `ncs`/`sclk`/`copi` (≥2)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ncs`  in  1  SPI chip select, active low (asynchronous pin)
- `sclk`  in  1  SPI clock (asynchronous pin)
- `copi`  in  1  controller-out data (asynchronous pin)
- `cipo`  out  1  peripheral-out read data
- `cipo_oe`  out  1  1 while a read data phase is active (pad enable)
- `regs_q`  out  NUM_REGS*DATA_W  flattened registers; reg k at `[k*DATA_W +: DATA_W]`
- `wr_strobe`  out  1  one-cycle pulse when a write commits
- `wr_addr`  out  ADDR_W  address of the last committed write
- `frame_err`  out  1  one-cycle pulse when a frame is rejected

## Operation
- **Synchronisers:** all three pins pass through `SYNC_STAGES` flops.
  - Edges are detected from the last two stages: `sclk` rise/fall, `ncs` fall/rise.
  - Reset values: `ncs` chain = 1, `sclk` chain = 0, `copi` chain = 0.
- **Frame format:** `FRAME = 1 + ADDR_W + DATA_W` bits, MSB-first, sampled on `sclk` rise.
  - Bit 0 is R/W (1 = write).
  - Next `ADDR_W` bits are the address.
  - Last `DATA_W` bits are the data.
- **FSM states:** IDLE, CMD, ADDR, DATA, DONE.
  - IDLE→CMD on `ncs` fall; bit counter cleared.
  - CMD→ADDR after 1 bit.
  - ADDR→DATA after `ADDR_W` bits.
  - DATA→DONE after `DATA_W` bits.
  - Any state→IDLE on `ncs` rise.
- **Overflow:** in DONE, further `sclk` rises set a sticky overflow flag. Data is not shifted.
- **Commit on `ncs` rise:**
  - Valid write (state DONE, no overflow, R/W = 1, address < `NUM_REGS`): only the addressed register is updated. `wr_strobe`=1 and `wr_addr` is updated in the same cycle.
  - Any state other than DONE, or overflow set, or address ≥ `NUM_REGS` on a write: `frame_err`=1. No register changes.
  - Valid read: no commit, no error.
  - `ncs` rise in IDLE produces nothing.
- **Read path** (R/W = 0):
  - On the cycle the last address bit is sampled, load the shift register with reg[addr] (all zeros if addr ≥ `NUM_REGS`) and set `cipo_oe`=1.
  - `cipo` = shift MSB. Shift left on each detected `sclk` fall while in DATA.
  - Incoming `copi` data bits are ignored.
  - `cipo_oe`/`cipo` return to 0 on `ncs` rise or reset.
- **Simultaneous events:** an `ncs` rise and an `sclk` rise detected in the same cycle resolve as `ncs` rise; the bit is discarded.
- **Reset values:** all registers 0; `cipo`, `cipo_oe`, `wr_strobe`, `frame_err` = 0; `wr_addr` = 0; FSM IDLE.
- **Reset mid-frame:** everything is cleared immediately. No partial commit. The next frame starts only on a fresh detected `ncs` fall.

## Timing
- Pin-to-detect latency: `SYNC_STAGES`+1 `clk` cycles.
- Write latency: register and `wr_strobe` update `SYNC_STAGES`+1 cycles after `ncs` rises at the pin.
- Clock ratio:
  - `clk` ≥ 8× `sclk`, so `cipo` settles (`SYNC_STAGES`+2 cycles after the pin `sclk` fall) before the next rise.
  - `sclk` high and low ≥ 2 `clk` periods each.
- Minimum `ncs` high between frames: 4 `clk` cycles.
- `wr_strobe` and `frame_err` are never both high, and each lasts exactly 1 cycle.

## Test plan
All scenarios use defaults (8/7/5). Frame bits are given MSB-first.

- **Write:** frame 1, 0000000, 0xA5 → reg0 = 0xA5, regs1–4 unchanged, `wr_strobe` 1 cycle, `wr_addr` = 0, `frame_err` = 0.
- **Write then read:** write 0x3C to addr 2, then frame 0, 0000010, 8 dummy bits → `cipo` samples 0,0,1,1,1,1,0,0 on the 8 data `sclk` rises, `cipo_oe` high only in the data phase, registers unchanged.
- **Bad frames:**
  - 15-bit frame → `frame_err` pulse, no register change.
  - 17-bit frame → `frame_err` pulse, no register change.
  - Write to addr 7 → `frame_err` pulse, no register change.
- **Back-to-back writes:** 0x11→addr0 then 0x22→addr1 with `ncs` high 4 cycles → reg0 = 0x11, reg1 = 0x22, two separate `wr_strobe` pulses.
- **Reset mid-frame:** assert `rst` after 10 bits of a write to addr3 → all regs 0, no strobe. A following full write of 0x7E to addr3 → reg3 = 0x7E.
- **Edge race:** `ncs` rise in the same cycle as the 16th `sclk` rise → frame rejected with `frame_err`, register unchanged.
